// File: rtl/scan_port_ctrl.sv
// ---------------------------------------------------------------------------
// scan_port_ctrl
//
// Core-side controller for the parallel scan port. The raw pad signals are
// synchronised, the host strobe protocol is decoded into single 32-bit
// config-memory reads and writes, read data is returned over the 16-bit scan
// bus as a low half then a high half, and the exec-start request is forwarded
// to the core as a one-cycle pulse.
//
// Ports
//   clk, reset_n          core clock, asynchronous active-low reset
//   chip_en               pad level; 0 parks the block in IDLE
//   scan_data_in[15:0]    pad word (address half or data half)
//   scan_data_or_addr     1 = word is an address half, 0 = data half
//   read_write            1 = write, 0 = read
//   data_addr_valid[1:0]  strobes: [0] low half, [1] high half
//   scan_start_exec       exec-start request pad
//   scan_data_out[15:0]   read-back half-word
//   scan_data_oe          high while scan_data_out is driven
//   data_out_valid        read-back half valid
//   mem_req/mem_we        memory request / write enable
//   mem_addr, mem_wdata   registered word address / write data
//   mem_gnt               request accepted this cycle
//   mem_rvalid, mem_rdata read data return
//   start_exec            one-cycle exec-start pulse
//   busy                  controller not in IDLE (exposes FSM activity)
//   proto_err             sticky: a strobe edge arrived while busy
//
// Memory handshake: mem_req (with mem_we/mem_addr/mem_wdata stable) stays
// high until the cycle mem_gnt is sampled high; that cycle completes the
// request. Read data is taken in the first mem_rvalid cycle after the grant.
// ---------------------------------------------------------------------------
module scan_port_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 8,
    parameter int AUTO_INC    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chip_en,
    input  logic [15:0]       scan_data_in,
    input  logic              scan_data_or_addr,
    input  logic              read_write,
    input  logic [1:0]        data_addr_valid,
    input  logic              scan_start_exec,
    output logic [15:0]       scan_data_out,
    output logic              scan_data_oe,
    output logic              data_out_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              start_exec,
    output logic              busy,
    output logic              proto_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_OUT_LO  = 3'd4,
        S_OUT_HI  = 3'd5
    } state_t;

    localparam int PAD_W = 22;
    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    // ---------------- pad synchronisers ----------------
    // All async pads share one synchroniser chain of SYNC_STAGES flops.
    logic [PAD_W-1:0] pad_raw;
    logic [PAD_W-1:0] pad_s;
    logic [PAD_W-1:0] sync_q [SYNC_STAGES];

    assign pad_raw = {chip_en, scan_data_in, scan_data_or_addr, read_write,
                      data_addr_valid, scan_start_exec};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pad_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign pad_s = sync_q[SYNC_STAGES-1];

    logic        chip_en_s;
    logic [15:0] word_s;
    logic        or_addr_s;
    logic        rw_s;
    logic [1:0]  dav_s;
    logic        start_s;

    assign chip_en_s = pad_s[21];
    assign word_s    = pad_s[20:5];
    assign or_addr_s = pad_s[4];
    assign rw_s      = pad_s[3];
    assign dav_s     = pad_s[2:1];
    assign start_s   = pad_s[0];

    // ---------------- edge detection ----------------
    // Edge registers always track the synchronised level, so a strobe that is
    // still high when chip_en returns does not produce a spurious event.
    logic [1:0] dav_prev;
    logic       start_prev;
    logic [1:0] dav_rise;
    logic       start_rise;
    logic       ev_any;

    assign dav_rise   = dav_s & ~dav_prev;
    assign start_rise = start_s & ~start_prev;
    assign ev_any     = |dav_rise;

    // ---------------- state and datapath registers ----------------
    state_t             state, state_d;
    logic [ADDR_W-1:0]  addr, addr_d, addr_inc;
    logic [31:0]        wdata, wdata_d;
    logic [31:0]        rdata, rdata_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               pending, pending_d;
    logic               proto_err_q, proto_err_d;
    logic               start_exec_q, start_exec_d;

    // Wraps modulo 2^ADDR_W naturally.
    assign addr_inc = (AUTO_INC != 0) ? addr + ADDR_W'(1) : addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            addr         <= '0;
            wdata        <= '0;
            rdata        <= '0;
            cnt          <= '0;
            pending      <= 1'b0;
            proto_err_q  <= 1'b0;
            start_exec_q <= 1'b0;
            dav_prev     <= '0;
            start_prev   <= 1'b0;
        end else begin
            state        <= state_d;
            addr         <= addr_d;
            wdata        <= wdata_d;
            rdata        <= rdata_d;
            cnt          <= cnt_d;
            pending      <= pending_d;
            proto_err_q  <= proto_err_d;
            start_exec_q <= start_exec_d;
            dav_prev     <= dav_s;
            start_prev   <= start_s;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d      = state;
        addr_d       = addr;
        wdata_d      = wdata;
        rdata_d      = rdata;
        cnt_d        = cnt;
        pending_d    = pending;
        proto_err_d  = proto_err_q;
        start_exec_d = 1'b0;

        if (!chip_en_s) begin
            // Disabled: abandon any transfer, keep addr/wdata.
            state_d     = S_IDLE;
            cnt_d       = '0;
            pending_d   = 1'b0;
            proto_err_d = 1'b0;
        end else begin
            if (start_rise) begin
                pending_d = 1'b1;
            end
            // The exec pulse waits for an IDLE cycle with no strobe event.
            if ((state == S_IDLE) && pending && !ev_any) begin
                start_exec_d = 1'b1;
                pending_d    = start_rise;
            end
            if (ev_any && (state != S_IDLE)) begin
                proto_err_d = 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (ev_any) begin
                        if (or_addr_s) begin
                            if (dav_rise[0]) begin
                                addr_d[15:0] = word_s;
                            end
                            // Upper address bits exist only when ADDR_W > 16.
                            if (dav_rise[1] && (ADDR_W > 16)) begin
                                addr_d = ADDR_W'({word_s, addr_d[15:0]});
                            end
                        end else if (rw_s) begin
                            if (dav_rise[0]) begin
                                wdata_d[15:0] = word_s;
                            end
                            if (dav_rise[1]) begin
                                wdata_d[31:16] = word_s;
                                state_d        = S_WR_REQ;
                            end
                        end else begin
                            state_d = S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (mem_gnt) begin
                        addr_d  = addr_inc;
                        state_d = S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt) begin
                        state_d = S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_d = mem_rdata;
                        cnt_d   = '0;
                        state_d = S_OUT_LO;
                    end
                end
                S_OUT_LO: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_OUT_HI;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                S_OUT_HI: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_d   = '0;
                        addr_d  = addr_inc;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign busy           = (state != S_IDLE);
    assign mem_req        = (state == S_WR_REQ) || (state == S_RD_REQ);
    assign mem_we         = (state == S_WR_REQ);
    assign mem_addr       = addr;
    assign mem_wdata      = wdata;
    assign scan_data_oe   = (state == S_OUT_LO) || (state == S_OUT_HI);
    assign data_out_valid = scan_data_oe;
    assign scan_data_out  = (state == S_OUT_LO) ? rdata[15:0]  :
                            (state == S_OUT_HI) ? rdata[31:16] : 16'h0000;
    assign start_exec     = start_exec_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_scan_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_port_ctrl
//
// Bench for scan_port_ctrl (ADDR_W=16, SYNC_STAGES=2, HOLD_CYC=8, AUTO_INC=1).
// Host operations are issued at transaction level; a memory responder checks
// each granted request against an expected queue, a read-back monitor checks
// the two output halves, and a transaction-level model tracks address, write
// data and exec pulses.
// ---------------------------------------------------------------------------
module tb_scan_port_ctrl;

  localparam int HOLD = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        chip_en = 1'b1;
  logic [15:0] scan_data_in = '0;
  logic        scan_data_or_addr = 1'b0;
  logic        read_write = 1'b0;
  logic [1:0]  data_addr_valid = '0;
  logic        scan_start_exec = 1'b0;
  logic [15:0] scan_data_out;
  logic        scan_data_oe;
  logic        data_out_valid;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        start_exec;
  logic        busy;
  logic        proto_err;

  scan_port_ctrl #(.ADDR_W(16), .SYNC_STAGES(2), .HOLD_CYC(HOLD), .AUTO_INC(1)) dut (
    .clk(clk), .reset_n(reset_n), .chip_en(chip_en), .scan_data_in(scan_data_in),
    .scan_data_or_addr(scan_data_or_addr), .read_write(read_write),
    .data_addr_valid(data_addr_valid), .scan_start_exec(scan_start_exec),
    .scan_data_out(scan_data_out), .scan_data_oe(scan_data_oe),
    .data_out_valid(data_out_valid), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .start_exec(start_exec),
    .busy(busy), .proto_err(proto_err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [48:0] exp_q[$];     // {we, addr, wdata}
  logic [31:0] exp_rd_q[$];  // read words expected on the scan bus

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int          gnt_delay = 0;
  int          rd_delay = 0;
  logic [31:0] next_rdata = '0;
  logic        rd_pending = 1'b0;
  logic [31:0] rd_word = '0;

  initial begin : responder
    int wait_cnt;
    int rd_cnt;
    logic [48:0] e;
    wait_cnt = 0;
    rd_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_rvalid) begin
        mem_rvalid = 1'b0;
      end else if (rd_pending) begin
        if (rd_cnt >= rd_delay) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_word;
          rd_pending = 1'b0;
          rd_cnt = 0;
        end else begin
          rd_cnt++;
        end
      end
      if (mem_gnt) begin
        mem_gnt = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt >= gnt_delay) begin
          check("req_expected", 64'(exp_q.size() != 0), 64'(1));
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          check("req_we", 64'(mem_we), 64'(e[48]));
          check("req_addr", 64'(mem_addr), 64'(e[47:32]));
          if (e[48]) check("req_wdata", 64'(mem_wdata), 64'(e[31:0]));
          mem_gnt = 1'b1;
          wait_cnt = 0;
          if (!mem_we) begin
            rd_pending = 1'b1;
            rd_cnt = 0;
            rd_word = next_rdata;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- read-back monitor ----------------
  initial begin : rd_mon
    int pos;
    logic [31:0] cur;
    logic prev_v;
    logic [15:0] exp_half;
    pos = 0;
    cur = '0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (data_out_valid) begin
        if (pos == 0) begin
          check("rd_expected", 64'(exp_rd_q.size() != 0), 64'(1));
          cur = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : '0;
        end
        exp_half = (pos < HOLD) ? cur[15:0] : cur[31:16];
        check("rd_half", 64'(scan_data_out), 64'(exp_half));
        check("rd_oe", 64'(scan_data_oe), 64'(1));
        pos++;
        if (pos == 2 * HOLD) pos = 0;
      end else if (prev_v) begin
        check("rd_len", 64'(pos), 64'(0));
        pos = 0;
      end
      prev_v = data_out_valid;
    end
  end

  // ---------------- exec pulse monitor ----------------
  int pulses = 0;
  int last_pulse_cyc = -1;
  initial begin : exec_mon
    forever begin
      @(negedge clk);
      if (start_exec) begin
        pulses++;
        last_pulse_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic or_addr, input logic rw, input logic [1:0] bits,
                        input logic [15:0] word);
    @(negedge clk);
    scan_data_or_addr = or_addr;
    read_write = rw;
    scan_data_in = word;
    @(negedge clk);
    data_addr_valid = bits;
    repeat (5) @(negedge clk);
    data_addr_valid = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || data_out_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  kind;       // 0 address, 1 write, 2 read
    logic [1:0]  bits;
    logic [15:0] word;
    logic [15:0] word_hi;
    int          gnt_d;
    int          rd_d;
    logic [31:0] rdata;
    logic [15:0] req_addr;
    logic [31:0] exp_wdata;
    logic [15:0] exp_addr_after;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] kind, input logic [1:0] bits,
                              input logic [15:0] word, input logic [15:0] word_hi,
                              input int gnt_d, input int rd_d, input logic [31:0] rdata,
                              input logic [15:0] req_addr, input logic [31:0] exp_wdata,
                              input logic [15:0] exp_addr_after);
    vec_t v;
    v.kind = kind; v.bits = bits; v.word = word; v.word_hi = word_hi;
    v.gnt_d = gnt_d; v.rd_d = rd_d; v.rdata = rdata; v.req_addr = req_addr;
    v.exp_wdata = exp_wdata; v.exp_addr_after = exp_addr_after;
    return v;
  endfunction

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin : main
    logic [15:0] m_addr, m_wlo, m_whi, w, w2;
    logic [31:0] rd;
    int exp_pulses, p0, idle_cyc, k, op, mode, oe_seen;
    logic [1:0] b;

    vecs[0] = mk(2'd0, 2'b01, 16'h0010, 16'h0000, 0, 0, 32'h0, 16'h0000, 32'h0, 16'h0010);
    vecs[1] = mk(2'd1, 2'b01, 16'h5678, 16'h1234, 3, 0, 32'h0, 16'h0010, 32'h12345678, 16'h0011);
    vecs[2] = mk(2'd0, 2'b01, 16'h0020, 16'h0000, 0, 0, 32'h0, 16'h0000, 32'h0, 16'h0020);
    vecs[3] = mk(2'd2, 2'b01, 16'h0000, 16'h0000, 1, 2, 32'hCAFEBEEF, 16'h0020, 32'h0, 16'h0021);
    vecs[4] = mk(2'd0, 2'b10, 16'hABCD, 16'h0000, 0, 0, 32'h0, 16'h0000, 32'h0, 16'h0021);
    vecs[5] = mk(2'd0, 2'b11, 16'hFFFF, 16'h0000, 0, 0, 32'h0, 16'h0000, 32'h0, 16'hFFFF);
    vecs[6] = mk(2'd1, 2'b11, 16'h0F0F, 16'h0000, 2, 0, 32'h0, 16'hFFFF, 32'h0F0F0F0F, 16'h0000);
    vecs[7] = mk(2'd2, 2'b10, 16'h0000, 16'h0000, 0, 0, 32'h00000001, 16'h0000, 32'h0, 16'h0001);
    exp_pulses = 0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req", 64'(mem_req), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_out", 64'({scan_data_oe, data_out_valid, scan_data_out}), 64'(0));
    check("rst_flags", 64'({start_exec, proto_err, mem_we}), 64'(0));
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(0));

    // table-driven host transactions
    for (int i = 0; i < 8; i++) begin
      gnt_delay = vecs[i].gnt_d;
      rd_delay = vecs[i].rd_d;
      next_rdata = vecs[i].rdata;
      if (vecs[i].kind == 2'd0) begin
        strobe(1'b1, 1'b0, vecs[i].bits, vecs[i].word);
      end else if (vecs[i].kind == 2'd1) begin
        exp_q.push_back({1'b1, vecs[i].req_addr, vecs[i].exp_wdata});
        if (vecs[i].bits == 2'b11) begin
          strobe(1'b0, 1'b1, 2'b11, vecs[i].word);
        end else begin
          strobe(1'b0, 1'b1, 2'b01, vecs[i].word);
          strobe(1'b0, 1'b1, 2'b10, vecs[i].word_hi);
        end
      end else begin
        exp_q.push_back({1'b0, vecs[i].req_addr, 32'h0});
        exp_rd_q.push_back(vecs[i].rdata);
        strobe(1'b0, 1'b0, vecs[i].bits, vecs[i].word);
      end
      wait_idle();
      check("vec_addr_after", 64'(mem_addr), 64'(vecs[i].exp_addr_after));
    end
    m_addr = 16'h0001;
    m_wlo = 16'h0F0F;
    m_whi = 16'h0F0F;

    // strobe edge during RD_WAIT is dropped and flags proto_err
    gnt_delay = 1;
    rd_delay = 30;
    next_rdata = 32'h13579BDF;
    exp_q.push_back({1'b0, m_addr, 32'h0});
    exp_rd_q.push_back(32'h13579BDF);
    strobe(1'b0, 1'b0, 2'b01, 16'h0000);
    check("rdwait_busy", 64'(busy), 64'(1));
    check("proto_err_clear", 64'(proto_err), 64'(0));
    strobe(1'b0, 1'b1, 2'b01, 16'h1111);
    check("proto_err_set", 64'(proto_err), 64'(1));
    wait_idle();
    m_addr = m_addr + 16'd1;
    check("proto_err_sticky", 64'(proto_err), 64'(1));
    check("dropped_wdata", 64'(mem_wdata), 64'({m_whi, m_wlo}));
    @(negedge clk);
    chip_en = 1'b0;
    @(negedge clk);
    chip_en = 1'b1;
    repeat (4) @(negedge clk);
    check("proto_err_cleared", 64'(proto_err), 64'(0));
    // high-half-only write reuses the retained low half
    gnt_delay = 0;
    m_whi = 16'h2222;
    exp_q.push_back({1'b1, m_addr, m_whi, m_wlo});
    strobe(1'b0, 1'b1, 2'b10, 16'h2222);
    wait_idle();
    m_addr = m_addr + 16'd1;
    check("hi_only_addr", 64'(mem_addr), 64'(m_addr));

    // chip_en dropped while a read waits for its grant
    gnt_delay = 1000;
    strobe(1'b0, 1'b0, 2'b01, 16'h0000);
    check("abandon_req_before", 64'(mem_req), 64'(1));
    chip_en = 1'b0;
    repeat (4) @(negedge clk);
    check("abandon_req_after", 64'(mem_req), 64'(0));
    check("abandon_busy", 64'(busy), 64'(0));
    chip_en = 1'b1;
    repeat (4) @(negedge clk);
    gnt_delay = 0;
    rd_word = 32'hDEAD0000;
    rd_delay = 0;
    rd_pending = 1'b1;
    oe_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (scan_data_oe) oe_seen++;
    end
    check("late_rvalid_oe", 64'(oe_seen), 64'(0));
    check("abandon_addr", 64'(mem_addr), 64'(m_addr));

    // exec request during OUT_HI: one pulse, the cycle after IDLE entry
    gnt_delay = 0;
    rd_delay = 0;
    next_rdata = 32'h0BADF00D;
    exp_q.push_back({1'b0, m_addr, 32'h0});
    exp_rd_q.push_back(32'h0BADF00D);
    p0 = pulses;
    fork
      strobe(1'b0, 1'b0, 2'b01, 16'h0000);
    join_none
    k = 0;
    while (!data_out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("out_started", 64'(data_out_valid), 64'(1));
    repeat (HOLD + 1) @(negedge clk);
    scan_start_exec = 1'b1;
    repeat (2) @(negedge clk);
    scan_start_exec = 1'b0;
    @(negedge clk);
    scan_start_exec = 1'b1;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    idle_cyc = cyc;
    repeat (6) @(negedge clk);
    scan_start_exec = 1'b0;
    check("exec_one_pulse", 64'(pulses - p0), 64'(1));
    check("exec_pulse_cycle", 64'(last_pulse_cyc), 64'(idle_cyc + 1));
    exp_pulses = 1;
    wait_idle();
    m_addr = m_addr + 16'd1;

    // randomized host traffic against the transaction model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      gnt_delay = $urandom_range(0, 4);
      rd_delay = $urandom_range(0, 4);
      w = 16'($urandom);
      w2 = 16'($urandom);
      if (op == 0) begin
        b = 2'($urandom_range(1, 3));
        if (b[0]) m_addr = w;
        strobe(1'b1, 1'($urandom_range(0, 1)), b, w);
      end else if (op == 1) begin
        mode = $urandom_range(0, 2);
        if (mode == 0) begin
          m_wlo = w; m_whi = w2;
          exp_q.push_back({1'b1, m_addr, m_whi, m_wlo});
          strobe(1'b0, 1'b1, 2'b01, w);
          strobe(1'b0, 1'b1, 2'b10, w2);
        end else if (mode == 1) begin
          m_wlo = w; m_whi = w;
          exp_q.push_back({1'b1, m_addr, m_whi, m_wlo});
          strobe(1'b0, 1'b1, 2'b11, w);
        end else begin
          m_whi = w2;
          exp_q.push_back({1'b1, m_addr, m_whi, m_wlo});
          strobe(1'b0, 1'b1, 2'b10, w2);
        end
        m_addr = m_addr + 16'd1;
      end else if (op == 2) begin
        rd = $urandom;
        next_rdata = rd;
        exp_q.push_back({1'b0, m_addr, 32'h0});
        exp_rd_q.push_back(rd);
        strobe(1'b0, 1'b0, 2'($urandom_range(1, 2)), w);
        m_addr = m_addr + 16'd1;
      end else begin
        @(negedge clk);
        scan_start_exec = 1'b1;
        repeat (5) @(negedge clk);
        scan_start_exec = 1'b0;
        repeat (4) @(negedge clk);
        exp_pulses++;
      end
      wait_idle();
      check("rand_addr", 64'(mem_addr), 64'(m_addr));
      check("rand_wdata", 64'(mem_wdata), 64'({m_whi, m_wlo}));
    end
    check("exec_pulse_total", 64'(pulses), 64'(exp_pulses));
    check("req_queue_drained", 64'(exp_q.size()), 64'(0));
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'(0));

    // reset asserted mid-operation
    gnt_delay = 1000;
    strobe(1'b0, 1'b0, 2'b01, 16'h0000);
    check("midrst_req_before", 64'(mem_req), 64'(1));
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_req", 64'(mem_req), 64'(0));
    check("midrst_regs", 64'({mem_addr, mem_wdata}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // overall time guard
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
